sdio_clk_gen: RTL and testbench
===============================

# sdio_clk_gen

Parametrised SD/SDIO card-clock generator, next generation of the host clock block. It divides sd_clk into the card clock and gates it on enable, stop and pause. It applies divider changes glitch-free and produces the power-up initialisation clock burst (74 cycles by default). It also produces the single-cycle tx/rx sampling strobes used by the command and data paths.

## Interface
- DIV_W, 8: width of divider value; half-period = div+1 sd_clk cycles.
- INIT_CYC, 74: number of card-clock cycles generated per init burst (≥1).
- sd_clk  in  1  system clock; all logic on posedge.
- rstn  in  1  asynchronous, active-low reset.
- clk_en  in  1  level; request card clock running.
- div_in  in  DIV_W  requested divider; sampled only at safe points (below).
- pause  in  1  level; request clock stop-low (buffer full/empty back-pressure).
- init_req  in  1  pulse; start init burst.
- tx_pos  in  1  1: tx strobe before rising edge; 0: before falling edge.
- rx_neg  in  1  1: rx strobe before falling edge; 0: before rising edge.
- clk_o  out  1  card clock (registered).
- clk_oe  out  1  card clock output enable (registered).
- tx_en  out  1  tx strobe, combinational from state/counter.
- rx_en  out  1  rx strobe, combinational from state/counter.
- div_cur  out  DIV_W  divider in use.
- paused  out  1  clock held low due to pause.
- init_busy  out  1  init burst in progress.
- init_done  out  1  one-cycle pulse at burst completion.

## Operation
- States: OFF, RUN, PAUSED, STOPPING. Half-period counter cnt (DIV_W), init counter icnt (clog2(INIT_CYC+1)).
- Reset: state OFF; cnt=0, clk_o=0, clk_oe=0, div_cur=0, paused=0, init_busy=0, init_done=0, icnt=0.
- Edge point E: state RUN/STOPPING and cnt==div_cur. At E: cnt<=0, clk_o<=~clk_o; otherwise cnt<=cnt+1. Rising toggle = E with clk_o=0, falling = E with clk_o=1.
- OFF: clk_o=0, clk_oe=0, cnt=0, div_cur<=div_in every cycle. clk_en=1 -> RUN, clk_oe<=1.
- RUN, divider: div_cur<=div_in only at a falling toggle (start of low phase). Active half-periods are never shortened or truncated.
- RUN, pause: pause=1 at a rising toggle point suppresses the rise. Next state PAUSED, clk_o stays 0, cnt<=0.
- PAUSED: clk_oe=1, clk_o=0, paused=1, cnt=0, div_cur<=div_in.
  - pause=0 -> RUN; a full low half-period (div_cur+1 cycles) precedes the next rise.
  - clk_en=0 -> OFF.
- RUN -> STOPPING on clk_en=0. STOPPING counts like RUN but ignores pause.
  - At the falling toggle: OFF, clk_oe<=0 in the same cycle.
  - Entering with clk_o=0: the low phase and one full high phase complete first.
  - clk_en=1 in STOPPING -> RUN with no counter disturbance.
- Init burst: init_req in RUN with init_busy=0 -> init_busy<=1, icnt<=0.
  - icnt increments at each falling toggle.
  - At the falling toggle where icnt==INIT_CYC-1: init_busy<=0, init_done pulses.
  - While busy: pause is ignored and tx_en=rx_en=0.
  - init_req while busy, or outside RUN: ignored.
  - Leaving RUN, or clk_en=0, during the burst aborts it: init_busy<=0, no init_done.
- tx_en = (RUN|STOPPING) & cnt==div_cur & !init_busy & (tx_pos ? ~clk_o : clk_o).
- rx_en = same qualifier & (rx_neg ? clk_o : ~clk_o).
- Both strobes are 0 in OFF and PAUSED.

## Timing
- Card period = 2*(div_cur+1) sd_clk cycles; 50% duty.
- div=0 gives sd_clk/2.
- Enable latency: clk_en rises at cycle t -> clk_oe=1 at t+1. First rise at t+1+div_cur+1.
- Strobes are asserted in the cycle before the corresponding clk_o edge register update.
- A divider change takes effect at the first falling toggle after div_in changes.
- A stop always ends with clk_o=0 and a complete high phase. Minimum high and low widths are always div_cur+1.
- pause asserted during a high phase: the high phase and the low phase complete, then the clock holds low.
- Async reset mid-burst or mid-phase returns all outputs to their reset values immediately.

## Test plan
- div_in=3, clk_en=1: clk_oe rises 1 cycle later. Period = 8 cycles, high = 4 cycles; tx_en (tx_pos=0) high exactly in each cycle before a falling toggle.
- Running at div=3, change div_in=1 mid-high-phase: high phase stays 4 cycles. Next low = 2 cycles, then period 4; no runt pulse.
- pause=1 during high at div=2: high and low complete, clock holds low, paused=1, no strobes. pause=0: first rise 3 cycles later.
- clk_en=0 at cnt=1 of low phase, div=4: low completes, full 5-cycle high, fall, clk_oe=0 in that cycle, state OFF.
- init_req at div=0, INIT_CYC=74: exactly 74 rising edges while init_busy=1. tx_en/rx_en stay 0. init_done pulses once at the 74th fall. A second init_req mid-burst is ignored.
- rstn low mid-burst: clk_o=clk_oe=init_busy=0 immediately. After release with clk_en=1: normal run, no init_done.

Source files
------------

// File: rtl/sdio_clk_gen.sv
// SD/SDIO card-clock generator: divides sd_clk, gates on enable/stop/pause, runs the
// power-up init burst and produces the tx/rx sampling strobes.
module sdio_clk_gen #(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned INIT_CYC = 74
) (
  input  logic             sd_clk,
  input  logic             rstn,
  input  logic             clk_en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             pause,
  input  logic             init_req,
  input  logic             tx_pos,
  input  logic             rx_neg,
  output logic             clk_o,
  output logic             clk_oe,
  output logic             tx_en,
  output logic             rx_en,
  output logic [DIV_W-1:0] div_cur,
  output logic             paused,
  output logic             init_busy,
  output logic             init_done
);

  localparam int unsigned IcntW = $clog2(INIT_CYC + 1);
  localparam logic [IcntW-1:0] ILast = IcntW'(INIT_CYC - 1);

  typedef enum logic [1:0] {StOff, StRun, StPaused, StStopping} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IcntW-1:0] icnt_q, icnt_d;
  logic             clk_q, clk_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic counting, at_e, rise_pt, fall_pt;

  assign counting = (state_q == StRun) || (state_q == StStopping);
  assign at_e     = counting && (cnt_q == div_q);
  assign rise_pt  = at_e && !clk_q;
  assign fall_pt  = at_e && clk_q;

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StOff;
      cnt_q   <= '0;
      div_q   <= '0;
      icnt_q  <= '0;
      clk_q   <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      icnt_q  <= icnt_d;
      clk_q   <= clk_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    icnt_d  = icnt_q;
    clk_d   = clk_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Half-period counter shared by RUN and STOPPING; overridden per state below.
    if (counting) begin
      if (at_e) begin
        cnt_d = '0;
        clk_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      StOff: begin
        clk_d  = 1'b0;
        oe_d   = 1'b0;
        cnt_d  = '0;
        div_d  = div_in;
        busy_d = 1'b0;
        icnt_d = '0;
        if (clk_en) begin
          state_d = StRun;
          oe_d    = 1'b1;
        end
      end
      StRun: begin
        // Divider only changes at the start of a low phase, so no phase is cut short.
        if (fall_pt) div_d = div_in;
        if (!clk_en) begin
          state_d = StStopping;
          busy_d  = 1'b0;
        end else if (busy_q) begin
          if (fall_pt) begin
            if (icnt_q == ILast) begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end else begin
              icnt_d = icnt_q + 1'b1;
            end
          end
        end else if (init_req) begin
          busy_d = 1'b1;
          icnt_d = '0;
        end else if (rise_pt && pause) begin
          state_d = StPaused;
          clk_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StPaused: begin
        clk_d = 1'b0;
        cnt_d = '0;
        oe_d  = 1'b1;
        div_d = div_in;
        if (!clk_en) begin
          state_d = StOff;
          oe_d    = 1'b0;
        end else if (!pause) begin
          state_d = StRun;
        end
      end
      StStopping: begin
        if (clk_en) begin
          state_d = StRun;
          if (fall_pt) div_d = div_in;
        end else if (fall_pt) begin
          state_d = StOff;
          oe_d    = 1'b0;
          clk_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = StOff;
    endcase
  end

  always_comb begin
    tx_en  = at_e && !busy_q && (tx_pos ? !clk_q : clk_q);
    rx_en  = at_e && !busy_q && (rx_neg ? clk_q : !clk_q);
    paused = (state_q == StPaused);
  end

  assign clk_o     = clk_q;
  assign clk_oe    = oe_q;
  assign div_cur   = div_q;
  assign init_busy = busy_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_sdio_clk_gen.sv
// Directed self-checking bench for sdio_clk_gen; outputs sampled on the falling edge.
module tb_sdio_clk_gen;

  logic       sd_clk;
  logic       rstn;
  logic       clk_en;
  logic [7:0] div_in;
  logic       pause;
  logic       init_req;
  logic       tx_pos;
  logic       rx_neg;
  logic       clk_o;
  logic       clk_oe;
  logic       tx_en;
  logic       rx_en;
  logic [7:0] div_cur;
  logic       paused;
  logic       init_busy;
  logic       init_done;

  int total = 0;
  int bad   = 0;

  sdio_clk_gen #(
    .DIV_W   (8),
    .INIT_CYC(74)
  ) dut (
    .sd_clk   (sd_clk),
    .rstn     (rstn),
    .clk_en   (clk_en),
    .div_in   (div_in),
    .pause    (pause),
    .init_req (init_req),
    .tx_pos   (tx_pos),
    .rx_neg   (rx_neg),
    .clk_o    (clk_o),
    .clk_oe   (clk_oe),
    .tx_en    (tx_en),
    .rx_en    (rx_en),
    .div_cur  (div_cur),
    .paused   (paused),
    .init_busy(init_busy),
    .init_done(init_done)
  );

  initial sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

  task automatic tick();
    @(negedge sd_clk);
  endtask

  // Leaves the DUT at sample 1: RUN, cnt=0, start of the first low phase.
  task automatic start_run(input logic [7:0] d);
    rstn = 1'b0; clk_en = 1'b0; pause = 1'b0; init_req = 1'b0; div_in = d;
    tick();
    rstn = 1'b1;
    tick();
    clk_en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; clk_en = 1'b1; div_in = 8'd5; pause = 1'b0; init_req = 1'b1;
    tx_pos = 1'b0; rx_neg = 1'b0;
    tick(); tick();
    total++; if (clk_o !== 1'b0) begin bad++; $display("FAIL reset_clk_o got=%b want=0", clk_o); end
    total++; if (clk_oe !== 1'b0) begin bad++; $display("FAIL reset_clk_oe got=%b want=0", clk_oe); end
    total++; if (div_cur !== 8'd0) begin bad++; $display("FAIL reset_div got=%0d want=0", div_cur); end
    total++; if ({tx_en, rx_en, paused, init_busy, init_done} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {tx_en, rx_en, paused, init_busy, init_done});
    end
    init_req = 1'b0;
  endtask

  task automatic test_enable();
    logic ec, et, er;
    rstn = 1'b0; clk_en = 1'b0; div_in = 8'd3; tx_pos = 1'b0; rx_neg = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    total++; if (clk_oe !== 1'b0) begin bad++; $display("FAIL off_oe got=%b want=0", clk_oe); end
    total++; if (div_cur !== 8'd3) begin bad++; $display("FAIL off_div got=%0d want=3", div_cur); end
    clk_en = 1'b1;
    tick();
    total++; if (clk_oe !== 1'b1) begin bad++; $display("FAIL en_latency_oe got=%b want=1", clk_oe); end
    for (int k = 1; k <= 16; k++) begin
      ec = (((k - 1) / 4) % 2) == 1;
      et = (k % 8) == 0;
      er = (k % 8) == 4;
      total++; if (clk_o !== ec) begin bad++; $display("FAIL en_clk k=%0d got=%b want=%b", k, clk_o, ec); end
      total++; if (tx_en !== et) begin bad++; $display("FAIL en_tx k=%0d got=%b want=%b", k, tx_en, et); end
      total++; if (rx_en !== er) begin bad++; $display("FAIL en_rx k=%0d got=%b want=%b", k, rx_en, er); end
      tick();
    end
  endtask

  task automatic test_div_change();
    logic       ec;
    logic [7:0] ed;
    start_run(8'd3);
    for (int k = 1; k < 6; k++) tick();
    total++; if (clk_o !== 1'b1) begin bad++; $display("FAIL div_mid_high got=%b want=1", clk_o); end
    div_in = 8'd1;
    for (int k = 7; k <= 16; k++) begin
      tick();
      ec = (k <= 8) ? 1'b1 : ((((k - 9) / 2) % 2) == 1);
      ed = (k <= 8) ? 8'd3 : 8'd1;
      total++; if (clk_o !== ec) begin bad++; $display("FAIL div_clk k=%0d got=%b want=%b", k, clk_o, ec); end
      total++; if (div_cur !== ed) begin bad++; $display("FAIL div_cur k=%0d got=%0d want=%0d", k, div_cur, ed); end
    end
  endtask

  task automatic test_pause();
    logic ec;
    tx_pos = 1'b1; rx_neg = 1'b0;
    start_run(8'd2);
    for (int k = 1; k < 4; k++) tick();
    pause = 1'b1;
    for (int k = 5; k <= 9; k++) begin
      tick();
      ec = (k <= 6);
      total++; if (clk_o !== ec) begin bad++; $display("FAIL pause_drain k=%0d got=%b want=%b", k, clk_o, ec); end
      total++; if (paused !== 1'b0) begin bad++; $display("FAIL pause_early k=%0d got=%b want=0", k, paused); end
    end
    for (int k = 10; k <= 14; k++) begin
      tick();
      total++; if ({clk_o, clk_oe, paused} !== 3'b011) begin
        bad++; $display("FAIL pause_hold k=%0d got=%b want=011", k, {clk_o, clk_oe, paused});
      end
      total++; if ({tx_en, rx_en} !== 2'b00) begin
        bad++; $display("FAIL pause_strobe k=%0d got=%b want=00", k, {tx_en, rx_en});
      end
    end
    pause = 1'b0;
    for (int k = 15; k <= 18; k++) begin
      tick();
      ec = (k == 18);
      total++; if (clk_o !== ec) begin bad++; $display("FAIL resume_clk k=%0d got=%b want=%b", k, clk_o, ec); end
      total++; if (paused !== 1'b0) begin bad++; $display("FAIL resume_paused k=%0d got=%b want=0", k, paused); end
    end
    tx_pos = 1'b0;
  endtask

  task automatic test_stop();
    logic ec, eo;
    start_run(8'd4);
    for (int k = 1; k < 12; k++) tick();
    clk_en = 1'b0;
    for (int k = 13; k <= 23; k++) begin
      tick();
      ec = (k >= 16) && (k <= 20);
      eo = (k <= 20);
      total++; if (clk_o !== ec) begin bad++; $display("FAIL stop_clk k=%0d got=%b want=%b", k, clk_o, ec); end
      total++; if (clk_oe !== eo) begin bad++; $display("FAIL stop_oe k=%0d got=%b want=%b", k, clk_oe, eo); end
    end
  endtask

  task automatic test_init();
    int   rises, dones, done_at, strobes;
    logic prev;
    rises = 0; dones = 0; done_at = 0; strobes = 0;
    tx_pos = 1'b0; rx_neg = 1'b0;
    start_run(8'd0);
    prev = clk_o;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    total++; if (init_busy !== 1'b1) begin bad++; $display("FAIL init_start got=%b want=1", init_busy); end
    for (int k = 2; k <= 200; k++) begin
      if (clk_o && !prev && init_busy) rises++;
      if (init_done) begin dones++; done_at = k; end
      if (init_busy && (tx_en || rx_en)) strobes++;
      prev = clk_o;
      init_req = (k == 50);
      tick();
    end
    init_req = 1'b0;
    total++; if (rises !== 74) begin bad++; $display("FAIL init_rises got=%0d want=74", rises); end
    total++; if (dones !== 1) begin bad++; $display("FAIL init_done_count got=%0d want=1", dones); end
    total++; if (done_at !== 149) begin bad++; $display("FAIL init_done_at got=%0d want=149", done_at); end
    total++; if (strobes !== 0) begin bad++; $display("FAIL init_strobes got=%0d want=0", strobes); end
    total++; if (init_busy !== 1'b0) begin bad++; $display("FAIL init_end_busy got=%b want=0", init_busy); end
    total++; if (rx_en !== 1'b1) begin bad++; $display("FAIL post_init_rx got=%b want=1", rx_en); end
  endtask

  task automatic test_reset_mid_burst();
    logic ec;
    int   dones;
    dones = 0;
    start_run(8'd0);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    total++; if ({clk_o, init_busy} !== 2'b11) begin
      bad++; $display("FAIL pre_rst got=%b want=11", {clk_o, init_busy});
    end
    #2 rstn = 1'b0;
    #1;
    total++; if ({clk_o, clk_oe, init_busy} !== 3'b000) begin
      bad++; $display("FAIL async_rst got=%b want=000", {clk_o, clk_oe, init_busy});
    end
    tick();
    rstn = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      ec = ((k - 1) % 2) == 1;
      if (init_done) dones++;
      total++; if ({clk_o, clk_oe} !== {ec, 1'b1}) begin
        bad++; $display("FAIL rst_rerun k=%0d got=%b want=%b1", k, {clk_o, clk_oe}, ec);
      end
      tick();
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", dones); end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_div_change();
    test_pause();
    test_stop();
    test_init();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
